// File: rtl/sdram_bridge.sv
// CPU strobe interface to SDRAM controller req/ack bridge with reset delay, byte masks and a watchdog.
// Optional write posting is enabled by defining SDRAM_WPOST_EN.
module sdram_bridge #(
  parameter int DW      = 16,
  parameter int AW      = 21,
  parameter int RST_DLY = 4,
  parameter int TMO     = 255
) (
  input  logic              clk_p,
  input  logic              sdram_reset,
  input  logic              sdram_stb,
  input  logic              sdram_we,
  input  logic [DW/8-1:0]   sdram_sel,
  input  logic [AW:1]       sdram_adr,
  input  logic [DW-1:0]     sdram_out,
  output logic [DW-1:0]     sdram_dat,
  output logic              sdram_ack,
  output logic              sdram_ready,
  output logic              tmo_err,
  output logic              ctl_rst_n,
  input  logic              ctl_init_done,
  output logic              ctl_wr_req,
  output logic              ctl_rd_req,
  input  logic              ctl_wr_ack,
  input  logic              ctl_rd_ack,
  output logic [AW:1]       ctl_addr,
  output logic [DW-1:0]     ctl_wdata,
  input  logic [DW-1:0]     ctl_rdata,
  output logic [DW/8-1:0]   ctl_dm,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] ST_RST_WAIT = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_REQ      = 3'd2;
  localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef SDRAM_WPOST_EN
  localparam logic [2:0] ST_WPOST    = 3'd4;
`endif

  localparam logic [15:0] RST_LAST = 16'(RST_DLY - 1);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        reply;
  logic        req_hit;

  // Only the ack matching the outstanding request completes it.
  assign req_hit   = (ctl_wr_req & ctl_wr_ack) | (ctl_rd_req & ctl_rd_ack);
  assign sdram_ack = sdram_stb & reply;
  assign dbg_state = state;

  always_ff @(posedge clk_p or posedge sdram_reset) begin
    if (sdram_reset) begin
      state       <= ST_RST_WAIT;
      cnt         <= '0;
      reply       <= 1'b0;
      ctl_rst_n   <= 1'b0;
      ctl_wr_req  <= 1'b0;
      ctl_rd_req  <= 1'b0;
      ctl_dm      <= '0;
      ctl_addr    <= '0;
      ctl_wdata   <= '0;
      sdram_dat   <= '0;
      sdram_ready <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      sdram_ready <= ctl_rst_n & ctl_init_done;
      case (state)
        ST_RST_WAIT: begin
          if (cnt == RST_LAST) begin
            ctl_rst_n <= 1'b1;
            cnt       <= '0;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_IDLE: begin
          if (sdram_stb && sdram_ready) begin
            ctl_addr  <= sdram_adr;
            ctl_wdata <= sdram_out;
            ctl_dm    <= sdram_we ? ~sdram_sel : '0;
            cnt       <= '0;
            if (sdram_we) begin
              ctl_wr_req <= 1'b1;
`ifdef SDRAM_WPOST_EN
              reply <= 1'b1;
              state <= ST_WPOST;
`else
              state <= ST_REQ;
`endif
            end else begin
              ctl_rd_req <= 1'b1;
              state      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A completing ack outranks a watchdog expiry in the same cycle.
          if (req_hit) begin
            if (ctl_rd_req) sdram_dat <= ctl_rdata;
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            reply      <= 1'b1;
            state      <= ST_DONE;
          end else if (cnt == TMO_LAST) begin
            ctl_wr_req <= 1'b0;
            ctl_rd_req <= 1'b0;
            tmo_err    <= 1'b1;
            sdram_dat  <= '1;
            reply      <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_DONE: begin
          if (!sdram_stb) begin
            reply <= 1'b0;
            state <= ST_IDLE;
          end
        end
`ifdef SDRAM_WPOST_EN
        ST_WPOST: begin
          if (!sdram_stb) reply <= 1'b0;
          // If the CPU still holds its strobe, finish its handshake in DONE.
          if (ctl_wr_ack || cnt == TMO_LAST) begin
            ctl_wr_req <= 1'b0;
            if (!ctl_wr_ack) tmo_err <= 1'b1;
            state <= (reply && sdram_stb) ? ST_DONE : ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bridge.sv
// Directed bench for sdram_bridge (RST_DLY=4, TMO=8); inputs driven and outputs sampled 1ns after each rising edge.
module tb_sdram_bridge;
  localparam int DW = 16;
  localparam int AW = 21;
  localparam int NB = DW / 8;

  logic            clk_p = 1'b0;
  logic            sdram_reset = 1'b1;
  logic            sdram_stb = 1'b0;
  logic            sdram_we = 1'b0;
  logic [NB-1:0]   sdram_sel = '0;
  logic [AW:1]     sdram_adr = '0;
  logic [DW-1:0]   sdram_out = '0;
  logic [DW-1:0]   sdram_dat;
  logic            sdram_ack;
  logic            sdram_ready;
  logic            tmo_err;
  logic            ctl_rst_n;
  logic            ctl_init_done = 1'b1;
  logic            ctl_wr_req;
  logic            ctl_rd_req;
  logic            ctl_wr_ack = 1'b0;
  logic            ctl_rd_ack = 1'b0;
  logic [AW:1]     ctl_addr;
  logic [DW-1:0]   ctl_wdata;
  logic [DW-1:0]   ctl_rdata = '0;
  logic [NB-1:0]   ctl_dm;
  logic [2:0]      dbg_state;

  int checks = 0;
  int fails  = 0;

  sdram_bridge #(.DW(DW), .AW(AW), .RST_DLY(4), .TMO(8)) dut (
    .clk_p(clk_p), .sdram_reset(sdram_reset), .sdram_stb(sdram_stb), .sdram_we(sdram_we),
    .sdram_sel(sdram_sel), .sdram_adr(sdram_adr), .sdram_out(sdram_out), .sdram_dat(sdram_dat),
    .sdram_ack(sdram_ack), .sdram_ready(sdram_ready), .tmo_err(tmo_err), .ctl_rst_n(ctl_rst_n),
    .ctl_init_done(ctl_init_done), .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req),
    .ctl_wr_ack(ctl_wr_ack), .ctl_rd_ack(ctl_rd_ack), .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata),
    .ctl_rdata(ctl_rdata), .ctl_dm(ctl_dm), .dbg_state(dbg_state)
  );

  always #5 clk_p = ~clk_p;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk_p);
    #1;
  endtask

  task automatic cpu_start(input logic we, input logic [NB-1:0] sel, input logic [AW:1] adr,
                           input logic [DW-1:0] out);
    sdram_stb = 1'b1;
    sdram_we  = we;
    sdram_sel = sel;
    sdram_adr = adr;
    sdram_out = out;
  endtask

  task automatic test_reset();
    logic exp_rst_n;
    logic exp_ready;
    logic [70:0] outs;
    sdram_reset = 1'b1;
    repeat (3) tick();
    outs = {ctl_rst_n, ctl_wr_req, ctl_rd_req, ctl_dm, ctl_addr, ctl_wdata, sdram_dat,
            sdram_ack, sdram_ready, tmo_err, 8'h00};
    checks++; if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
    checks++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    sdram_reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp_rst_n = (e >= 4);
      exp_ready = (e >= 5);
      checks++; if (ctl_rst_n !== exp_rst_n) begin fails++; $display("FAIL rst_n_edge%0d: got %b want %b", e, ctl_rst_n, exp_rst_n); end
      checks++; if (sdram_ready !== exp_ready) begin fails++; $display("FAIL ready_edge%0d: got %b want %b", e, sdram_ready, exp_ready); end
      checks++; if (sdram_ack !== 1'b0) begin fails++; $display("FAIL ack_in_reset_wait%0d: got %b want 0", e, sdram_ack); end
    end
  endtask

  task automatic test_read();
    cpu_start(1'b0, 2'b01, 21'h12345, 16'h1111);
    tick();
    checks++; if (ctl_rd_req !== 1'b1 || ctl_wr_req !== 1'b0) begin fails++; $display("FAIL read_req: got rd=%b wr=%b want rd=1 wr=0", ctl_rd_req, ctl_wr_req); end
    checks++; if (ctl_addr !== 21'h12345) begin fails++; $display("FAIL read_addr: got %h want 12345", ctl_addr); end
    checks++; if (ctl_dm !== 2'b00) begin fails++; $display("FAIL read_dm: got %b want 00", ctl_dm); end
    repeat (2) begin
      tick();
      checks++; if (ctl_rd_req !== 1'b1 || sdram_ack !== 1'b0) begin fails++; $display("FAIL read_hold: got rd=%b ack=%b want rd=1 ack=0", ctl_rd_req, sdram_ack); end
    end
    ctl_rdata  = 16'hA5C3;
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (sdram_ack !== 1'b1) begin fails++; $display("FAIL read_ack: got %b want 1", sdram_ack); end
    checks++; if (sdram_dat !== 16'hA5C3) begin fails++; $display("FAIL read_data: got %h want a5c3", sdram_dat); end
    checks++; if (ctl_rd_req !== 1'b0) begin fails++; $display("FAIL read_req_drop: got %b want 0", ctl_rd_req); end
    tick();
    checks++; if (sdram_ack !== 1'b1) begin fails++; $display("FAIL read_ack_hold: got %b want 1", sdram_ack); end
    sdram_stb = 1'b0;
    #1;
    checks++; if (sdram_ack !== 1'b0) begin fails++; $display("FAIL read_ack_fall: got %b want 0", sdram_ack); end
    tick();
    checks++; if (dbg_state !== 3'd1) begin fails++; $display("FAIL read_back_idle: got %0d want 1", dbg_state); end
  endtask

  task automatic test_write();
    cpu_start(1'b1, 2'b10, 21'h00ABC, 16'hBEEF);
    tick();
    checks++; if (ctl_wr_req !== 1'b1 || ctl_rd_req !== 1'b0) begin fails++; $display("FAIL write_req: got wr=%b rd=%b want wr=1 rd=0", ctl_wr_req, ctl_rd_req); end
    checks++; if (ctl_dm !== 2'b01) begin fails++; $display("FAIL write_dm: got %b want 01", ctl_dm); end
    checks++; if (ctl_wdata !== 16'hBEEF) begin fails++; $display("FAIL write_data: got %h want beef", ctl_wdata); end
    checks++; if (ctl_addr !== 21'h00ABC) begin fails++; $display("FAIL write_addr: got %h want 00abc", ctl_addr); end
`ifdef SDRAM_WPOST_EN
    checks++; if (sdram_ack !== 1'b1) begin fails++; $display("FAIL write_post_ack: got %b want 1", sdram_ack); end
    sdram_stb = 1'b0;
    tick();
    checks++; if (ctl_wr_req !== 1'b1) begin fails++; $display("FAIL write_post_hold: got %b want 1", ctl_wr_req); end
    ctl_wr_ack = 1'b1;
    tick();
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b0 || sdram_ack !== 1'b0) begin fails++; $display("FAIL write_post_done: got wr=%b ack=%b want 0 0", ctl_wr_req, sdram_ack); end
`else
    repeat (2) begin
      tick();
      checks++; if (ctl_wr_req !== 1'b1 || sdram_ack !== 1'b0) begin fails++; $display("FAIL write_hold: got wr=%b ack=%b want wr=1 ack=0", ctl_wr_req, sdram_ack); end
    end
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b1) begin fails++; $display("FAIL write_ignores_rd_ack: got %b want 1", ctl_wr_req); end
    ctl_wr_ack = 1'b1;
    tick();
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b0 || sdram_ack !== 1'b1) begin fails++; $display("FAIL write_ack: got wr=%b ack=%b want wr=0 ack=1", ctl_wr_req, sdram_ack); end
    sdram_stb = 1'b0;
`endif
    tick();
    checks++; if (dbg_state !== 3'd1) begin fails++; $display("FAIL write_back_idle: got %0d want 1", dbg_state); end
  endtask

  task automatic test_ack_at_limit();
    cpu_start(1'b0, 2'b11, 21'h00100, 16'h0000);
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (ctl_rd_req !== 1'b1) begin fails++; $display("FAIL limit_hold%0d: got %b want 1", i, ctl_rd_req); end
    end
    ctl_rdata  = 16'h1234;
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (tmo_err !== 1'b0) begin fails++; $display("FAIL limit_tmo_err: got %b want 0", tmo_err); end
    checks++; if (sdram_ack !== 1'b1 || sdram_dat !== 16'h1234) begin fails++; $display("FAIL limit_reply: got ack=%b dat=%h want ack=1 dat=1234", sdram_ack, sdram_dat); end
    sdram_stb = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    cpu_start(1'b0, 2'b11, 21'h00200, 16'h0000);
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++; if (ctl_rd_req !== 1'b1 || tmo_err !== 1'b0) begin fails++; $display("FAIL tmo_hold%0d: got rd=%b err=%b want 1 0", i, ctl_rd_req, tmo_err); end
    end
    tick();
    checks++; if (ctl_rd_req !== 1'b0) begin fails++; $display("FAIL tmo_req_drop: got %b want 0", ctl_rd_req); end
    checks++; if (tmo_err !== 1'b1) begin fails++; $display("FAIL tmo_err_set: got %b want 1", tmo_err); end
    checks++; if (sdram_ack !== 1'b1 || sdram_dat !== 16'hFFFF) begin fails++; $display("FAIL tmo_reply: got ack=%b dat=%h want ack=1 dat=ffff", sdram_ack, sdram_dat); end
    sdram_stb = 1'b0;
    tick();
    checks++; if (tmo_err !== 1'b1) begin fails++; $display("FAIL tmo_err_sticky: got %b want 1", tmo_err); end
  endtask

  task automatic test_abort();
    cpu_start(1'b0, 2'b11, 21'h00300, 16'h0000);
    tick();
    tick();
    sdram_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (sdram_ack !== 1'b0 || ctl_rd_req !== 1'b1) begin fails++; $display("FAIL abort_hold%0d: got ack=%b rd=%b want 0 1", i, sdram_ack, ctl_rd_req); end
    end
    ctl_rdata  = 16'h0F0F;
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (sdram_ack !== 1'b0 || ctl_rd_req !== 1'b0) begin fails++; $display("FAIL abort_complete: got ack=%b rd=%b want 0 0", sdram_ack, ctl_rd_req); end
    tick();
    checks++; if (dbg_state !== 3'd1) begin fails++; $display("FAIL abort_idle: got %0d want 1", dbg_state); end
    cpu_start(1'b0, 2'b11, 21'h1FFFF, 16'h0000);
    tick();
    checks++; if (ctl_rd_req !== 1'b1 || ctl_addr !== 21'h1FFFF) begin fails++; $display("FAIL abort_next_req: got rd=%b addr=%h want 1 1ffff", ctl_rd_req, ctl_addr); end
    ctl_rdata  = 16'h5A5A;
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (sdram_ack !== 1'b1 || sdram_dat !== 16'h5A5A) begin fails++; $display("FAIL abort_next_reply: got ack=%b dat=%h want 1 5a5a", sdram_ack, sdram_dat); end
    sdram_stb = 1'b0;
    tick();
  endtask

`ifdef SDRAM_WPOST_EN
  task automatic test_wpost_then_read();
    cpu_start(1'b1, 2'b11, 21'h00400, 16'hCAFE);
    tick();
    checks++; if (sdram_ack !== 1'b1 || ctl_wr_req !== 1'b1) begin fails++; $display("FAIL wpost_ack: got ack=%b wr=%b want 1 1", sdram_ack, ctl_wr_req); end
    sdram_stb = 1'b0;
    tick();
    cpu_start(1'b0, 2'b11, 21'h00500, 16'h0000);
    for (int i = 2; i <= 5; i++) begin
      tick();
      checks++; if (ctl_rd_req !== 1'b0 || sdram_ack !== 1'b0) begin fails++; $display("FAIL wpost_holdoff%0d: got rd=%b ack=%b want 0 0", i, ctl_rd_req, sdram_ack); end
    end
    ctl_wr_ack = 1'b1;
    tick();
    ctl_wr_ack = 1'b0;
    checks++; if (ctl_wr_req !== 1'b0 || ctl_rd_req !== 1'b0) begin fails++; $display("FAIL wpost_wr_done: got wr=%b rd=%b want 0 0", ctl_wr_req, ctl_rd_req); end
    tick();
    checks++; if (ctl_rd_req !== 1'b1 || ctl_dm !== 2'b00) begin fails++; $display("FAIL wpost_read_req: got rd=%b dm=%b want 1 00", ctl_rd_req, ctl_dm); end
    ctl_rdata  = 16'h7E57;
    ctl_rd_ack = 1'b1;
    tick();
    ctl_rd_ack = 1'b0;
    checks++; if (sdram_ack !== 1'b1 || sdram_dat !== 16'h7E57) begin fails++; $display("FAIL wpost_read_reply: got ack=%b dat=%h want 1 7e57", sdram_ack, sdram_dat); end
    sdram_stb = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
`ifdef SDRAM_WPOST_EN
    test_wpost_then_read();
`endif
    test_ack_at_limit();
    test_abort();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
